// File: rtl/outport_fifo.sv
// outport_fifo: buffered replacement for the single-register OUT port.
// Captures the bus value on each OutPortin strobe into a DEPTH-entry FIFO and
// drains it to an external device over a valid/ready handshake.
//
// Parameters:
//   WIDTH      - data width of bus and entries
//   DEPTH      - number of entries (power of two, >= 2)
//   LATCH_LAST - 1: OutPort_out holds the last drained value when empty; 0: reads 0
// Ports:
//   clock       - rising-edge clock
//   clear       - asynchronous active-high reset
//   OutPortin   - write strobe from the control unit
//   BusMuxOut   - datapath bus value to store
//   OutPort_out - data presented to the device
//   out_valid   - OutPort_out holds an undelivered entry
//   out_ready   - device accepts the entry this cycle
//   count       - number of stored entries, 0..DEPTH
//   full/empty  - occupancy flags
//   stall       - control unit must hold its T-state (write while full)
//   ovf         - sticky flag: a write was dropped
//   ovf_clr     - synchronous clear of ovf
module outport_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LATCH_LAST = 1,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             OutPortin,
  input  logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] OutPort_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             stall,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [WIDTH-1:0] last;

  logic pop;
  logic push;
  logic drop;

  assign full      = (count == FullCount);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign stall     = full & OutPortin;

  assign pop  = out_valid & out_ready;
  // A pop in the same cycle frees the slot the write lands in.
  assign push = OutPortin & (!full | pop);
  assign drop = OutPortin & full & !pop;

  always_comb begin
    if (out_valid) begin
      OutPort_out = mem[rp];
    end else if (LATCH_LAST != 0) begin
      OutPort_out = last;
    end else begin
      OutPort_out = '0;
    end
  end

  // Storage is not reset; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wp] <= BusMuxOut;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      last  <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
        if (LATCH_LAST != 0) begin
          last <= mem[rp];
        end
      end
      if (push && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW + 1)'(1);
      end
      // Set has priority over the synchronous clear.
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_outport_fifo.sv
// Directed bench for outport_fifo (DEPTH=4). A second instance with
// LATCH_LAST=0 shares all inputs to check the empty-output behaviour.
module tb_outport_fifo;

  logic        clock;
  logic        clear;
  logic        OutPortin;
  logic [31:0] BusMuxOut;
  logic        out_ready;
  logic        ovf_clr;

  logic [31:0] OutPort_out;
  logic        out_valid;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        stall;
  logic        ovf;

  logic [31:0] z_out;
  logic        z_valid;
  logic [2:0]  z_count;
  logic        z_full;
  logic        z_empty;
  logic        z_stall;
  logic        z_ovf;

  int n_cmp = 0;
  int n_err = 0;

  outport_fifo #(.WIDTH(32), .DEPTH(4), .LATCH_LAST(1)) dut (
    .clock       (clock),
    .clear       (clear),
    .OutPortin   (OutPortin),
    .BusMuxOut   (BusMuxOut),
    .OutPort_out (OutPort_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .stall       (stall),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  outport_fifo #(.WIDTH(32), .DEPTH(4), .LATCH_LAST(0)) dut_z (
    .clock       (clock),
    .clear       (clear),
    .OutPortin   (OutPortin),
    .BusMuxOut   (BusMuxOut),
    .OutPort_out (z_out),
    .out_valid   (z_valid),
    .out_ready   (out_ready),
    .count       (z_count),
    .full        (z_full),
    .empty       (z_empty),
    .stall       (z_stall),
    .ovf         (z_ovf),
    .ovf_clr     (ovf_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    OutPortin = 1'b1;
    BusMuxOut = v;
    tick();
    OutPortin = 1'b0;
    BusMuxOut = 32'hDEAD_BEEF;
  endtask

  initial begin
    clear     = 1'b1;
    OutPortin = 1'b0;
    BusMuxOut = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    #1;
    // Reset values
    check("rst_out", OutPort_out, 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_stall", 32'(stall), 0);
    check("rst_ovf", 32'(ovf), 0);
    @(negedge clock);
    clear = 1'b0;
    #1;

    // Single push of 53, then one pop
    push(53);
    check("p53_out", OutPort_out, 53);
    check("p53_valid", 32'(out_valid), 1);
    check("p53_count", 32'(count), 1);
    check("p53_z_out", z_out, 53);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop53_valid", 32'(out_valid), 0);
    check("pop53_latch", OutPort_out, 53);
    check("pop53_z_zero", z_out, 0);
    check("pop53_empty", 32'(empty), 1);

    // Order and wrap-around with out_ready held high
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      push(32'(k));
      check("ord_out", OutPort_out, 32'(k));
      check("ord_count", 32'(count), 1);
    end
    tick();
    out_ready = 1'b0;
    check("ord_empty", 32'(empty), 1);
    check("ord_last", OutPort_out, 6);
    check("ord_ovf", 32'(ovf), 0);

    // Full and overflow
    for (int k = 10; k <= 13; k++) push(32'(k));
    check("full_flag", 32'(full), 1);
    check("full_count", 32'(count), 4);
    OutPortin = 1'b1;
    BusMuxOut = 14;
    #1;
    check("full_stall", 32'(stall), 1);
    tick();
    OutPortin = 1'b0;
    check("ovf_set", 32'(ovf), 1);
    check("ovf_count", 32'(count), 4);
    check("ovf_head", OutPort_out, 10);
    out_ready = 1'b1;
    for (int k = 10; k <= 13; k++) begin
      check("drain1", OutPort_out, 32'(k));
      tick();
    end
    out_ready = 1'b0;
    check("drain1_empty", 32'(empty), 1);
    check("drain1_last", OutPort_out, 13);
    check("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);

    // Simultaneous push and pop while full
    for (int k = 20; k <= 23; k++) push(32'(k));
    out_ready = 1'b1;
    OutPortin = 1'b1;
    BusMuxOut = 24;
    #1;
    check("pp_stall", 32'(stall), 1);
    tick();
    OutPortin = 1'b0;
    out_ready = 1'b0;
    check("pp_count", 32'(count), 4);
    check("pp_ovf", 32'(ovf), 0);
    check("pp_head", OutPort_out, 21);
    out_ready = 1'b1;
    for (int k = 21; k <= 24; k++) begin
      check("drain2", OutPort_out, 32'(k));
      tick();
    end
    out_ready = 1'b0;
    check("drain2_empty", 32'(empty), 1);

    // Mid-operation asynchronous clear with 3 entries and ovf set
    for (int k = 30; k <= 33; k++) push(32'(k));
    push(34);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pre_clr_count", 32'(count), 3);
    check("pre_clr_ovf", 32'(ovf), 1);
    #2;
    clear = 1'b1;
    #1;
    check("aclr_count", 32'(count), 0);
    check("aclr_empty", 32'(empty), 1);
    check("aclr_ovf", 32'(ovf), 0);
    check("aclr_out", OutPort_out, 0);
    check("aclr_valid", 32'(out_valid), 0);
    @(negedge clock);
    clear = 1'b0;
    #1;

    // ovf_clr coinciding with an overflowing push: set wins
    for (int k = 40; k <= 43; k++) push(32'(k));
    OutPortin = 1'b1;
    BusMuxOut = 44;
    ovf_clr   = 1'b1;
    tick();
    OutPortin = 1'b0;
    ovf_clr   = 1'b0;
    check("set_wins", 32'(ovf), 1);
    check("set_wins_count", 32'(count), 4);
    check("set_wins_head", OutPort_out, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
